// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the bidirectional PIO: register word addresses and
// edge-capture type encodings.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Multi-stage flop synchroniser bringing the pad values into the clk domain.
module soc_system_pio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/soc_system_pio_bidir_irq.sv
// Avalon-MM bidirectional PIO with per-bit direction and atomic set/clear.
// Edge capture, IRQMASK and irq exist only when PIO_EDGE_IRQ_EN is defined.
module soc_system_pio_bidir_irq
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic             irq
);

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [31:0]      r_readdata;

  assign w_wr    = chipselect && !write_n;
  assign w_wdata = writedata[WIDTH-1:0];

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign bidir_port[g] = r_dir[g] ? r_data_out[g] : 1'bz;
  end

  soc_system_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (bidir_port),
    .o_sync  (w_sync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= OUT_RESET;
      r_dir      <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:   r_data_out <= w_wdata;
        ADDR_DIR:    r_dir      <= w_wdata;
        ADDR_OUTSET: r_data_out <= r_data_out | w_wdata;
        ADDR_OUTCLR: r_data_out <= r_data_out & ~w_wdata;
        default: ;
      endcase
    end
  end

`ifdef PIO_EDGE_IRQ_EN
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [2:0]       r_arm;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;

  always_comb begin
    w_edge = '0;
    if (r_arm == ARM_DONE) begin
      if (EDGE_TYPE == EDGE_RISING)       w_edge = w_sync & ~r_prev;
      else if (EDGE_TYPE == EDGE_FALLING) w_edge = ~w_sync & r_prev;
      else                                w_edge = w_sync ^ r_prev;
    end
  end

  assign w_clr = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;

  // Arming masks the synchroniser filling up with pins that were static at reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
      r_arm     <= '0;
    end else begin
      r_prev    <= w_sync;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (r_arm != ARM_DONE) r_arm <= r_arm + 3'd1;
      if (w_wr && address == ADDR_IRQMASK) r_irqmask <= w_wdata;
    end
  end

  assign irq = |(r_edgecap & r_irqmask);
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= '0;
      case (address)
        ADDR_DATA:    r_readdata[WIDTH-1:0] <= w_sync;
        ADDR_DIR:     r_readdata[WIDTH-1:0] <= r_dir;
`ifdef PIO_EDGE_IRQ_EN
        ADDR_IRQMASK: r_readdata[WIDTH-1:0] <= r_irqmask;
        ADDR_EDGECAP: r_readdata[WIDTH-1:0] <= r_edgecap;
`endif
        default: ;
      endcase
    end
  end

  assign readdata = r_readdata;

endmodule

// File: tb/tb_soc_system_pio_bidir_irq.sv
// Directed bench for soc_system_pio_bidir_irq; edge/irq checks depend on
// PIO_EDGE_IRQ_EN matching the DUT build.
module tb_soc_system_pio_bidir_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  wire  [31:0] w_pins;
  logic [31:0] r_ext_en = '1;
  logic [31:0] r_ext_val = '0;
  logic [31:0] rd;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 32; g++) begin : g_ext
    assign w_pins[g] = r_ext_en[g] ? r_ext_val[g] : 1'bz;
  end

  soc_system_pio_bidir_irq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .bidir_port (w_pins),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(4);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("reset_rd%0d", a), rd, 32'h0);
    end
    check("reset_irq", {31'h0, irq}, 32'h0);

    // low half driven by the DUT, upper half by the bench
    r_ext_en  = 32'hFFFF_0000;
    r_ext_val = 32'hABCD_0000;
    bus_write(3'd1, 32'h0000_FFFF);
    bus_write(3'd0, 32'h1234_5678);
    check("pins_lo", {16'h0, w_pins[15:0]}, 32'h0000_5678);
    idle(3);
    bus_read(3'd0, rd);
    check("data_mixed", rd, 32'hABCD_5678);
    bus_read(3'd1, rd);
    check("dir_rd", rd, 32'h0000_FFFF);

    r_ext_en = 32'h0;
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd0, 32'h0000_00F0);
    bus_write(3'd4, 32'h0000_000F);
    check("outset_pins", w_pins, 32'h0000_00FF);
    bus_write(3'd5, 32'h0000_0081);
    check("outclr_pins", w_pins, 32'h0000_007E);
    idle(3);
    bus_read(3'd0, rd);
    check("outclr_data", rd, 32'h0000_007E);
    bus_read(3'd4, rd);
    check("outset_rd0", rd, 32'h0);
    bus_read(3'd5, rd);
    check("outclr_rd0", rd, 32'h0);

    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);
    check("addr6_rd0", rd, 32'h0);
    bus_read(3'd7, rd);
    check("addr7_rd0", rd, 32'h0);
    bus_read(3'd0, rd);
    check("data_after_6_7", rd, 32'h0000_007E);

`ifndef PIO_EDGE_IRQ_EN
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_read(3'd2, rd);
    check("addr2_rd0", rd, 32'h0);
    bus_read(3'd3, rd);
    check("addr3_rd0", rd, 32'h0);
    check("irq_tied0", {31'h0, irq}, 32'h0);
`endif

    // mid-operation reset with pin3 (and others) held high through release
    address = 3'd1;
    idle(1);
    reset_n = 1'b0;
    #1;
    check("async_rst_rd", readdata, 32'h0);
    r_ext_en  = 32'hFFFF_FFFF;
    r_ext_val = 32'h5A5A_5A5A;
    idle(2);
    reset_n = 1'b1;
    idle(5);
    bus_read(3'd1, rd);
    check("rst_dir", rd, 32'h0);
    bus_read(3'd0, rd);
    check("rst_data_in", rd, 32'h5A5A_5A5A);

`ifdef PIO_EDGE_IRQ_EN
    bus_read(3'd3, rd);
    check("arm_no_cap", rd, 32'h0);
    bus_write(3'd2, 32'h0000_0001);
    bus_read(3'd2, rd);
    check("irqmask_rd", rd, 32'h0000_0001);

    @(posedge clk); #1 r_ext_val[0] = 1'b1;
    idle(1);
    check("irq_p1", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq_p2", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq_p3", {31'h0, irq}, 32'h1);
    bus_read(3'd3, rd);
    check("edgecap_set", rd, 32'h0000_0001);
    bus_write(3'd3, 32'h0000_0001);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    bus_read(3'd3, rd);
    check("edgecap_clr", rd, 32'h0);

    r_ext_val[0] = 1'b0;
    idle(5);
    bus_read(3'd3, rd);
    check("fall_ignored", rd, 32'h0);

    @(posedge clk); #1 r_ext_val[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus_write(3'd3, 32'h0000_0001);
    check("set_wins_irq", {31'h0, irq}, 32'h1);
    bus_read(3'd3, rd);
    check("set_wins_cap", rd, 32'h0000_0001);
    bus_write(3'd2, 32'h0);
    check("mask_off_irq", {31'h0, irq}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
